// File: rtl/apb_mig_pkg.sv
// Shared types and constants for the APB-to-MIG native-UI bridge.
package apb_mig_pkg;

   // MIG native-UI side
   localparam int unsigned MIG_ADDR_W_DEF     = 27;
   localparam int unsigned MIG_DATA_W         = 128;
   localparam int unsigned MIG_STRB_W         = MIG_DATA_W / 8;

   // APB side
   localparam int unsigned APB_ADDR_W_DEF     = 32;
   localparam int unsigned APB_DATA_W         = 32;
   localparam int unsigned APB_STRB_W         = APB_DATA_W / 8;

   // 32-bit words per 128-bit MIG line
   localparam int unsigned MIG_LANES          = MIG_DATA_W / APB_DATA_W;

   // Default bound on cycles spent waiting on the MIG
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1023;

   typedef logic [MIG_DATA_W-1:0]     data_t;
   typedef logic [MIG_STRB_W-1:0]     strb_t;
   typedef logic [MIG_ADDR_W_DEF-1:0] mig_addr_t;

   typedef logic [APB_ADDR_W_DEF-1:0] apb_addr_t;
   typedef logic [APB_DATA_W-1:0]     apb_data_t;
   typedef logic [APB_STRB_W-1:0]     apb_strb_t;

   typedef logic [$clog2(MIG_LANES)-1:0] lane_t;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RD_WAIT,
      RESP
   } bridge_state_e;

endpackage

// File: rtl/apb_mig_word_lane.sv
// Maps a 32-bit APB word onto its lane of a 128-bit MIG line and back.
module apb_mig_word_lane
   import apb_mig_pkg::*;
(
   input  lane_t     lane_i,
   input  apb_data_t wdata_i,
   input  apb_strb_t wstrb_i,
   input  data_t     line_i,
   output data_t     wline_o,
   output strb_t     wstrb_o,
   output apb_data_t rword_o
);

   // Write data goes to every lane; only the addressed lane is strobed. Read picks one lane.
   always_comb begin
      wline_o = {MIG_LANES{wdata_i}};
      wstrb_o = '0;
      rword_o = '0;
      for (int i = 0; i < MIG_LANES; i++) begin
         if (lane_i == lane_t'(i)) begin
            wstrb_o[APB_STRB_W*i +: APB_STRB_W] = wstrb_i;
            rword_o                             = line_i[APB_DATA_W*i +: APB_DATA_W];
         end
      end
   end

endmodule

// File: rtl/apb_mig_bridge.sv
// APB slave issuing one MIG native-UI command per APB access, in the ui_clk domain.
module apb_mig_bridge
   import apb_mig_pkg::*;
#(
   parameter int unsigned APB_ADDR_W     = APB_ADDR_W_DEF,
   parameter int unsigned MIG_ADDR_W     = MIG_ADDR_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                  ui_clk_i,
   input  logic                  ui_rst_i,
   // APB
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [APB_ADDR_W-1:0] paddr_i,
   input  apb_data_t             pwdata_i,
   input  apb_strb_t             pstrb_i,
   output apb_data_t             prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   // MIG native UI
   output logic                  en_o,
   output logic                  w_en_o,
   output logic [MIG_ADDR_W-1:0] addr_o,
   output data_t                 data_o,
   output strb_t                 strb_o,
   input  data_t                 data_i,
   input  logic                  valid_i,
   input  logic                  ready_i,
   input  logic                  w_ready_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   bridge_state_e         state_q, state_d;
   logic                  pwrite_q, pwrite_d;
   logic [MIG_ADDR_W-1:0] addr_q, addr_d;
   lane_t                 lane_q, lane_d;
   apb_data_t             pwdata_q, pwdata_d;
   apb_strb_t             pstrb_q, pstrb_d;
   apb_data_t             prdata_q, prdata_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  drop_q, drop_d;

   logic                  addr_oor;
   logic                  timeout;
   apb_data_t             rd_word;

   // Anything at or above 2^(MIG_ADDR_W+1) bytes lies beyond the MIG address space
   assign addr_oor = (paddr_i >> (MIG_ADDR_W + 1)) != '0;
   assign timeout  = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

   apb_mig_word_lane u_word_lane (
      .lane_i  (lane_q),
      .wdata_i (pwdata_q),
      .wstrb_i (pstrb_q),
      .line_i  (data_i),
      .wline_o (data_o),
      .wstrb_o (strb_o),
      .rword_o (rd_word)
   );

   // Next-state logic: capture on APB setup, then run the MIG handshake and timeout
   always_comb begin
      state_d  = state_q;
      pwrite_d = pwrite_q;
      addr_d   = addr_q;
      lane_d   = lane_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      prdata_d = prdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      drop_d   = drop_q;

      // Read data arriving outside RD_WAIT is discarded; it retires a timed-out read
      if (drop_q && valid_i && (state_q != RD_WAIT)) begin
         drop_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               pwrite_d = pwrite_i;
               addr_d   = {paddr_i[MIG_ADDR_W:4], 3'b000};
               lane_d   = paddr_i[3:2];
               pwdata_d = pwdata_i;
               pstrb_d  = pstrb_i;
               prdata_d = '0;
               err_d    = 1'b0;
               cnt_d    = '0;
               if (addr_oor) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end else if (pwrite_i && (pstrb_i == '0)) begin
                  state_d = RESP;
               end else begin
                  state_d = CMD;
               end
            end
         end
         CMD: begin
            cnt_d = cnt_q + 1'b1;
            // A handshake in the final allowed cycle still wins over the timeout
            if (ready_i && (!pwrite_q || w_ready_i)) begin
               state_d = pwrite_q ? RESP : RD_WAIT;
            end else if (timeout) begin
               // Command never accepted, so no late read data will follow
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (valid_i) begin
               prdata_d = rd_word;
               state_d  = RESP;
            end else if (timeout) begin
               prdata_d = '0;
               err_d    = 1'b1;
               drop_d   = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers
   always_ff @(posedge ui_clk_i or posedge ui_rst_i) begin
      if (ui_rst_i) begin
         state_q  <= IDLE;
         pwrite_q <= 1'b0;
         addr_q   <= '0;
         lane_q   <= '0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         prdata_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pwrite_q <= pwrite_d;
         addr_q   <= addr_d;
         lane_q   <= lane_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         prdata_q <= prdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         drop_q   <= drop_d;
      end
   end

   // Outputs decoded from state; prdata is only presented during the response cycle
   always_comb begin
      en_o      = state_q == CMD;
      w_en_o    = (state_q == CMD) && pwrite_q;
      addr_o    = addr_q;
      pready_o  = state_q == RESP;
      pslverr_o = (state_q == RESP) && err_q;
      prdata_o  = (state_q == RESP) ? prdata_q : '0;
   end

endmodule

// File: tb/tb_apb_mig_bridge.sv
// Bench for apb_mig_bridge: directed plan plus randomized traffic against a word-memory model.
module tb_apb_mig_bridge;

   localparam int T = 16;

   logic         ui_clk = 1'b0;
   logic         ui_rst;
   logic         psel, penable, pwrite;
   logic [31:0]  paddr, pwdata, prdata;
   logic [3:0]   pstrb;
   logic         pready, pslverr;
   logic         en, w_en;
   logic [26:0]  addr;
   logic [127:0] mdata_w, mdata_r;
   logic [15:0]  mstrb;
   logic         valid, ready, w_ready;

   int checks   = 0;
   int failures = 0;

   // Reference: APB-visible 32-bit words. Bench-as-MIG: 128-bit lines.
   logic [31:0]  ref_mem [int unsigned];
   logic [127:0] mig_mem [int unsigned];

   apb_mig_bridge #(
      .APB_ADDR_W     (32),
      .MIG_ADDR_W     (27),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .ui_clk_i  (ui_clk),
      .ui_rst_i  (ui_rst),
      .psel_i    (psel),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .pstrb_i   (pstrb),
      .prdata_o  (prdata),
      .pready_o  (pready),
      .pslverr_o (pslverr),
      .en_o      (en),
      .w_en_o    (w_en),
      .addr_o    (addr),
      .data_o    (mdata_w),
      .strb_o    (mstrb),
      .data_i    (mdata_r),
      .valid_i   (valid),
      .ready_i   (ready),
      .w_ready_i (w_ready)
   );

   always #5 ui_clk = ~ui_clk;

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] init_word(input int unsigned widx);
      return (32'(widx) * 32'h9E37_79B1) + 32'h1234_5678;
   endfunction

   function automatic logic [31:0] ref_get(input int unsigned widx);
      if (ref_mem.exists(widx)) return ref_mem[widx];
      return init_word(widx);
   endfunction

   function automatic logic [127:0] mig_get(input int unsigned li);
      if (mig_mem.exists(li)) return mig_mem[li];
      return {init_word(4*li+3), init_word(4*li+2), init_word(4*li+1), init_word(4*li)};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_en"}, en, 1'b0);
      chk({tag, "_w_en"}, w_en, 1'b0);
      chk({tag, "_pready"}, pready, 1'b0);
      chk({tag, "_pslverr"}, pslverr, 1'b0);
      chk({tag, "_prdata"}, prdata, 32'h0);
      chk({tag, "_addr"}, addr, 27'h0);
      chk({tag, "_data"}, mdata_w, 128'h0);
      chk({tag, "_strb"}, mstrb, 16'h0);
   endtask

   // One APB transfer with the bench acting as MIG. Delays: cycles of en_o before
   // ready/w_ready, and cycles after the read handshake before valid_i.
   task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int rdy_dly, input int wrdy_dly,
                       input int val_dly, input bit no_valid, input string tag,
                       output logic [31:0] rd);
      int          k, en_seen, hs_k, resp_k, ev_k, exp_resp_k, exp_en;
      bit          hs, done, oor, exp_cmd, tmo, exp_err;
      logic [1:0]  lane;
      logic [26:0] exp_addr;
      logic [31:0] exp_rd, w;
      logic [127:0] line;
      int unsigned widx;

      // Expected outcome from the APB-level rules
      lane     = a[3:2];
      widx     = int'(a[27:2]);
      exp_addr = 27'(a[27:4]) << 3;
      oor      = a >= 32'h1000_0000;
      exp_cmd  = !oor && !(wr && st == 4'h0);
      if (!exp_cmd) begin
         ev_k = 0;
      end else if (wr) begin
         ev_k = ((rdy_dly > wrdy_dly) ? rdy_dly : wrdy_dly) + 1;
      end else begin
         ev_k = no_valid ? 1000000 : rdy_dly + 1 + val_dly;
      end
      tmo        = exp_cmd && (ev_k > T);
      exp_resp_k = !exp_cmd ? 1 : (tmo ? T + 1 : ev_k + 1);
      exp_err    = oor || tmo;
      if (!exp_cmd) exp_en = 0;
      else if (wr) exp_en = (ev_k > T) ? T : ev_k;
      else exp_en = (rdy_dly + 1 > T) ? T : rdy_dly + 1;
      exp_rd = (!wr && exp_cmd && !tmo) ? ref_get(widx) : 32'h0;

      // Setup phase, then access phase
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
      @(negedge ui_clk);
      penable = 1'b1;
      k = 1; en_seen = 0; hs = 1'b0; hs_k = 0; resp_k = 0; done = 1'b0;
      while (!done) begin
         if (pready) begin
            resp_k = k;
            done   = 1'b1;
         end else begin
            ready = 1'b0; w_ready = 1'b0; valid = 1'b0;
            if (en) begin
               en_seen++;
               chk({tag, "_w_en"}, w_en, wr);
               chk({tag, "_addr"}, addr, exp_addr);
               if (wr) begin
                  chk({tag, "_data"}, mdata_w, {4{wd}});
                  chk({tag, "_strb"}, mstrb, 16'(st) << (4 * lane));
               end
               ready   = en_seen > rdy_dly;
               w_ready = en_seen > wrdy_dly;
               if (ready && (!wr || w_ready)) begin
                  hs   = 1'b1;
                  hs_k = k;
                  if (wr) begin
                     line = mig_get(int'(addr >> 3));
                     for (int b = 0; b < 16; b++)
                        if (mstrb[b]) line[8*b +: 8] = mdata_w[8*b +: 8];
                     mig_mem[int'(addr >> 3)] = line;
                  end
               end
            end else if (hs && !wr && !no_valid && k == hs_k + val_dly) begin
               valid   = 1'b1;
               mdata_r = mig_get(int'(addr >> 3));
            end
            if (k > 300) begin
               checks++;
               failures++;
               $display("FAIL %s_no_pready: observed none after %0d cycles required pready", tag, k);
               done = 1'b1;
            end else begin
               @(negedge ui_clk);
               k++;
            end
         end
      end

      chk({tag, "_latency"}, 128'(resp_k), 128'(exp_resp_k));
      chk({tag, "_en_cycles"}, 128'(en_seen), 128'(exp_en));
      chk({tag, "_pslverr"}, pslverr, exp_err);
      chk({tag, "_prdata"}, prdata, exp_rd);
      rd = prdata;

      if (wr && exp_cmd && !tmo) begin
         w = ref_get(widx);
         for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
         ref_mem[widx] = w;
      end

      psel = 1'b0; penable = 1'b0; ready = 1'b0; w_ready = 1'b0; valid = 1'b0;
      @(negedge ui_clk);
      chk({tag, "_pready_one_cycle"}, pready, 1'b0);
   endtask

   initial begin
      logic [31:0] rd, a, wd;
      logic [3:0]  st;
      bit          wr;

      ui_rst = 1'b1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      mdata_r = '0; valid = 1'b0; ready = 1'b0; w_ready = 1'b0;
      repeat (2) @(negedge ui_clk);
      chk_idle_outputs("reset");
      ui_rst = 1'b0;
      @(negedge ui_clk);
      chk_idle_outputs("post_reset");

      // Write 0x18: line 1, lane 2
      xfer(1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 1'b0, "tp_write", rd);

      // Read 0x04 from a known line, valid five cycles after the command
      mig_mem[0] = 128'h3333_3333_2222_2222_1111_1111_0000_0000;
      ref_mem[0] = 32'h0000_0000;
      ref_mem[1] = 32'h1111_1111;
      ref_mem[2] = 32'h2222_2222;
      ref_mem[3] = 32'h3333_3333;
      xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 5, 1'b0, "tp_read", rd);
      chk("tp_read_literal", rd, 32'h1111_1111);

      // Write data path stalled for 10 cycles
      xfer(1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'h5, 0, 10, 1, 1'b0, "tp_wstall", rd);
      xfer(1'b0, 32'h0000_0024, 32'h0, 4'h0, 2, 0, 1, 1'b0, "tp_wstall_rb", rd);

      // Read that never returns data, then a stray valid, then a normal read
      xfer(1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 0, 1, 1'b1, "tp_timeout", rd);
      valid   = 1'b1;
      mdata_r = 128'hBADB_AD00_BADB_AD01_BADB_AD02_BADB_AD03;
      @(negedge ui_clk);
      valid = 1'b0;
      chk("stray_pready", pready, 1'b0);
      chk("stray_en", en, 1'b0);
      xfer(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1, 0, 2, 1'b0, "tp_after_timeout", rd);

      // Out-of-range and empty-strobe accesses never reach the MIG
      xfer(1'b0, 32'h1000_0000, 32'h0, 4'h0, 0, 0, 1, 1'b0, "tp_oor_rd", rd);
      xfer(1'b1, 32'h1000_0000, 32'h1234_5678, 4'hF, 0, 0, 1, 1'b0, "tp_oor_wr", rd);
      xfer(1'b1, 32'h0000_0040, 32'h1234_5678, 4'h0, 0, 0, 1, 1'b0, "tp_nostrb", rd);

      // Reset while a command is being offered
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0040;
      @(negedge ui_clk);
      penable = 1'b1;
      chk("rst_cmd_en_before", en, 1'b1);
      #2 ui_rst = 1'b1;
      #1 chk("rst_cmd_en_now", en, 1'b0);
      chk("rst_cmd_addr_now", addr, 27'h0);
      @(negedge ui_clk);
      psel = 1'b0; penable = 1'b0;
      ui_rst = 1'b0;
      @(negedge ui_clk);

      // Reset while waiting for read data
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0040;
      @(negedge ui_clk);
      penable = 1'b1;
      chk("rst_rd_en_before", en, 1'b1);
      ready = 1'b1;
      @(negedge ui_clk);
      ready = 1'b0;
      chk("rst_rd_in_wait_en", en, 1'b0);
      chk("rst_rd_in_wait_addr", addr, 27'h20);
      @(negedge ui_clk);
      #2 ui_rst = 1'b1;
      #1 chk_idle_outputs("rst_rd_now");
      @(negedge ui_clk);
      psel = 1'b0; penable = 1'b0;
      ui_rst = 1'b0;
      @(negedge ui_clk);
      xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 3, 1'b0, "post_rst_read", rd);

      // Randomized traffic over a small window so reads see earlier writes
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) a = 32'h1000_0000 | $urandom();
         else a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
         wd = $urandom();
         st = 4'($urandom_range(0, 15));
         xfer(wr, a, wd, st, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, 4), 1'b0, "rand", rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_mig_bridge.md
Name: apb_mig_bridge

Overview:
- APB3/APB4 slave that turns single 32-bit APB accesses into single 128-bit MIG native-UI commands.
- Sits directly upstream of the MIG user interface and drives the apb side of the mig_if handshake (en/w_en/addr/strb/data out; ready/w_ready/valid/data in).
- Runs entirely in the MIG ui_clk domain. CDC to any system APB clock is outside this block.
- Handles word-lane mapping, the command/write-data handshake, read-data capture, address-range errors and a response timeout.

Parameters:
- APB_ADDR_W, 32, APB address width.
- MIG_ADDR_W, 27, MIG address width (16-bit column units, x16 DDR3, burst 8).
- TIMEOUT_CYCLES, 1023, maximum cycles spent waiting on the MIG before an error response; must be ≥ 2.

Ports:
- ui_clk_i  in  1  MIG user-interface clock; the only clock.
- ui_rst_i  in  1  reset, asynchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  APB_ADDR_W  byte address.
- pwdata_i  in  32  write data.
- pstrb_i  in  4  byte strobes.
- prdata_o  out  32  read data.
- pready_o  out  1  APB ready.
- pslverr_o  out  1  APB error.
- en_o  out  1  MIG command valid.
- w_en_o  out  1  1 = write command, 0 = read command.
- addr_o  out  MIG_ADDR_W  MIG address.
- data_o  out  128  MIG write data.
- strb_o  out  16  MIG byte strobes, active-high.
- data_i  in  128  MIG read data.
- valid_i  in  1  read data valid.
- ready_i  in  1  MIG command ready.
- w_ready_i  in  1  MIG write-data ready.

Behaviour:
- Reset (async, takes effect immediately, including mid-transaction): state IDLE; all outputs 0; drop_pending 0; timeout counter 0. Any in-flight APB transfer is abandoned.
- FSM states: IDLE, CMD, RD_WAIT, RESP.
- IDLE, on psel_i & !penable_i (setup phase):
  - Capture pwrite, paddr, pwdata, pstrb.
  - If paddr ≥ 2^(MIG_ADDR_W+1): go to RESP with err=1.
  - Else if write with pstrb==0: go to RESP with err=0; no MIG command is issued.
  - Else: go to CMD.
- Address map: addr_o = {paddr[MIG_ADDR_W:4], 3'b000}. Word lane = paddr[3:2]. paddr[1:0] ignored.
- Write lanes: data_o = pwdata replicated ×4. strb_o = pstrb placed at bits [4*lane+3:4*lane], all other bits 0.
- CMD:
  - en_o=1, w_en_o=pwrite; addr_o, data_o, strb_o held stable.
  - Read: when ready_i=1, go to RD_WAIT.
  - Write: when ready_i & w_ready_i are both 1 in the same cycle, go to RESP, err=0.
  - en_o is high in the handshake cycle and drops the next cycle.
- RD_WAIT:
  - en_o=0. When valid_i=1: prdata register = data_i[32*lane+31:32*lane], go to RESP, err=0.
  - valid_i in the same cycle as leaving CMD is not possible; only valid_i seen in RD_WAIT counts.
- Timeout:
  - Counter clears on entering CMD and counts every cycle in CMD or RD_WAIT.
  - At TIMEOUT_CYCLES it forces RESP with err=1 and prdata=0.
  - A read timeout sets drop_pending.
- RESP:
  - pready_o=1 and pslverr_o=err for exactly one cycle, then IDLE.
  - prdata_o is valid only for reads; 0 for writes and errors.
  - Outside RESP, pready_o=0 and pslverr_o=0.
- Stray data: valid_i while not in RD_WAIT is discarded. If drop_pending=1, the first such valid_i clears drop_pending.
- Latency:
  - Write with MIG ready: setup T0, CMD T1, pready T2.
  - Read: pready one cycle after the valid_i cycle.
- Protocol assumption: one outstanding transfer at a time. psel/penable changes during CMD or RD_WAIT are ignored; captured values are used.

Decomposition:
- apb_mig_pkg gains:
  - apb_addr_t, apb_data_t (32), apb_strb_t (4);
  - MIG_LANES = 4;
  - state enum bridge_state_e {IDLE, CMD, RD_WAIT, RESP};
  - default TIMEOUT_CYCLES constant.
  - It keeps the existing data_t, strb_t, mig_addr_t.
- One combinational sub-module, apb_mig_word_lane:
  - write side: lane → replicated data / placed strobes;
  - read side: 128-bit line + lane → 32-bit word.

Test Plan:
- Write paddr=0x0000_0018, pwdata=0xDEADBEEF, pstrb=0xF, ready_i=w_ready_i=1 → one-cycle en_o with w_en_o=1, addr_o=0x0000008, strb_o=0x0F00, data_o=DEADBEEF×4; pready at T2, pslverr=0.
- Read paddr=0x04, valid_i 5 cycles after the command with data_i=0x33333333_22222222_11111111_00000000 → prdata=0x11111111, pready one cycle after valid_i.
- Write with ready_i=1 and w_ready_i held 0 for 10 cycles, then 1 → en_o high for 11 cycles, a single handshake, then pready.
- Read with valid_i never asserted, TIMEOUT_CYCLES=16 → pready with pslverr=1 and prdata=0 after 16 wait cycles. A later stray valid_i is dropped, and the next read returns its own data.
- paddr=0x1000_0000 (≥ 2^28) → no en_o; pready with pslverr=1. Write with pstrb=0 → no en_o; pready with pslverr=0.
- Assert ui_rst_i during RD_WAIT → en_o/pready_o go 0 immediately. After release, a new read completes normally.
